// File: rtl/irq_encoder_16x4.sv
// Sticky 16-line interrupt request encoder: latches requests, presents one
// eligible index at a time as CODE/VALID and retires it on ACK.
module irq_encoder_16x4 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] REQ,
    input  logic [15:0] MASK,
    input  logic        ACK,
    output logic        VALID,
    output logic [3:0]  CODE,
    output logic [15:0] PENDING
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0]  state;
    logic [15:0] pending;
    logic [3:0]  code;
    logic [15:0] elig;
    logic [15:0] clr;
    logic [3:0]  win;
    logic        retire;

    assign elig   = pending & ~MASK;
    assign retire = (state == S_PRESENT) && ACK;
    assign clr    = retire ? (16'b1 << code) : 16'b0;

    // The last assignment in the scan wins, so scan order sets priority.
    generate
        if (LOW_FIRST) begin : g_low_first
            always_comb begin
                win = 4'd0;
                for (int i = 15; i >= 0; i--)
                    if (elig[i]) win = 4'(i);
            end
        end else begin : g_high_first
            always_comb begin
                win = 4'd0;
                for (int i = 0; i < 16; i++)
                    if (elig[i]) win = 4'(i);
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            pending <= 16'h0000;
            code    <= 4'd0;
        end else begin
            // Set wins over clear: a re-request in the ACK cycle stays pending.
            pending <= (pending & ~clr) | REQ;
            case (state)
                S_IDLE: begin
                    if (|elig) begin
                        code  <= win;
                        state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ACK) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign VALID   = (state == S_PRESENT);
    assign CODE    = code;
    assign PENDING = pending;

endmodule

// File: tb/tb_irq_encoder_16x4.sv
// Directed bench for irq_encoder_16x4; a monitor scores each new presentation
// against a queue of expected codes, two instances cover both priority directions.
module tb_irq_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req0, mask0, req1, mask1;
    logic        ack0, ack1;
    logic        valid0, valid1;
    logic [3:0]  code0, code1;
    logic [15:0] pend0, pend1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    always #5 clk = ~clk;

    irq_encoder_16x4 #(.LOW_FIRST(1'b1)) dut_lo (
        .CLK(clk), .RST(rst), .REQ(req0), .MASK(mask0), .ACK(ack0),
        .VALID(valid0), .CODE(code0), .PENDING(pend0)
    );

    irq_encoder_16x4 #(.LOW_FIRST(1'b0)) dut_hi (
        .CLK(clk), .RST(rst), .REQ(req1), .MASK(mask1), .ACK(ack1),
        .VALID(valid1), .CODE(code1), .PENDING(pend1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising VALID is a new presentation, scored against the queue.
    logic prev_v0 = 1'b0, prev_v1 = 1'b0;
    always @(negedge clk) begin
        logic [3:0] e;
        if (valid0 && !prev_v0) begin
            n_tests++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL lo_code: unexpected presentation code=%0d", code0);
            end else begin
                e = exp_q0.pop_front();
                if (code0 !== e) begin
                    n_fail++;
                    $display("FAIL lo_code: got %0d expected %0d", code0, e);
                end
            end
        end
        if (valid1 && !prev_v1) begin
            n_tests++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL hi_code: unexpected presentation code=%0d", code1);
            end else begin
                e = exp_q1.pop_front();
                if (code1 !== e) begin
                    n_fail++;
                    $display("FAIL hi_code: got %0d expected %0d", code1, e);
                end
            end
        end
        prev_v0 <= valid0;
        prev_v1 <= valid1;
    end

    initial begin
        rst = 1'b1; req0 = 16'hFFFF; mask0 = '0; ack0 = 1'b0;
        req1 = '0; mask1 = '0; ack1 = 1'b0;

        // Reset held two edges with all requests high
        step(); step();
        chk("rst_pending", pend0, 16'h0000);
        chk("rst_valid",   {15'b0, valid0}, 16'h0);
        chk("rst_code",    {12'b0, code0}, 16'h0);
        rst = 1'b0; req0 = 16'h0000;
        step();
        chk("post_rst_pending", pend0, 16'h0000);
        chk("post_rst_valid",   {15'b0, valid0}, 16'h0);
        step();
        chk("post_rst_valid2",  {15'b0, valid0}, 16'h0);

        // Single request: 2-cycle latency to VALID
        req0 = 16'h0020; exp_q0.push_back(4'd5);
        step(); req0 = '0;
        chk("single_pending", pend0, 16'h0020);
        chk("single_valid_early", {15'b0, valid0}, 16'h0);
        step();
        chk("single_valid", {15'b0, valid0}, 16'h1);
        chk("single_code",  {12'b0, code0}, 16'd5);
        step();
        chk("single_hold", {15'b0, valid0}, 16'h1);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("single_ack_valid",   {15'b0, valid0}, 16'h0);
        chk("single_ack_pending", pend0, 16'h0000);

        // Priority ordering, low first, ACK held high
        req0 = 16'h8421;
        exp_q0.push_back(4'd0); exp_q0.push_back(4'd5);
        exp_q0.push_back(4'd10); exp_q0.push_back(4'd15);
        step(); req0 = '0; ack0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("lo_seq_valid%0d", i), {15'b0, valid0}, (i % 2 == 0) ? 16'h1 : 16'h0);
        end
        ack0 = 1'b0;
        chk("lo_seq_pending", pend0, 16'h0000);

        // Priority ordering, high first
        req1 = 16'h8421;
        exp_q1.push_back(4'd15); exp_q1.push_back(4'd10);
        exp_q1.push_back(4'd5);  exp_q1.push_back(4'd0);
        step(); req1 = '0; ack1 = 1'b1;
        for (int i = 0; i < 8; i++) step();
        ack1 = 1'b0;
        chk("hi_seq_pending", pend1, 16'h0000);
        chk("hi_seq_valid",   {15'b0, valid1}, 16'h0);

        // Masking
        mask0 = 16'h0001; req0 = 16'h0003; exp_q0.push_back(4'd1);
        step(); req0 = '0;
        step();
        chk("mask_code",  {12'b0, code0}, 16'd1);
        chk("mask_valid", {15'b0, valid0}, 16'h1);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("mask_ack_valid",   {15'b0, valid0}, 16'h0);
        chk("mask_ack_pending", pend0, 16'h0001);
        step();
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("idle_ack_ignored", pend0, 16'h0001);
        chk("masked_idle", {15'b0, valid0}, 16'h0);
        mask0 = 16'h0000; exp_q0.push_back(4'd0);
        step();
        chk("unmask_valid", {15'b0, valid0}, 16'h1);
        chk("unmask_code",  {12'b0, code0}, 16'd0);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("unmask_pending", pend0, 16'h0000);

        // Hold while presented, set wins over clear
        req0 = 16'h0010; exp_q0.push_back(4'd4);
        step(); req0 = '0;
        step();
        req0 = 16'h0001; step(); req0 = '0;
        chk("hold_code",    {12'b0, code0}, 16'd4);
        chk("hold_pending", pend0, 16'h0011);
        ack0 = 1'b1; req0 = 16'h0010; step(); ack0 = 1'b0; req0 = '0;
        chk("setwin_pending", pend0, 16'h0011);
        exp_q0.push_back(4'd0); exp_q0.push_back(4'd4);
        step();
        chk("setwin_next_code", {12'b0, code0}, 16'd0);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        step();
        chk("setwin_again_code", {12'b0, code0}, 16'd4);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("setwin_final_pending", pend0, 16'h0000);

        // Reset mid-presentation
        req0 = 16'h0180; exp_q0.push_back(4'd7);
        step(); req0 = '0;
        step();
        chk("mid_code",    {12'b0, code0}, 16'd7);
        chk("mid_pending", pend0, 16'h0180);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_valid",   {15'b0, valid0}, 16'h0);
        chk("mid_rst_code",    {12'b0, code0}, 16'h0);
        chk("mid_rst_pending", pend0, 16'h0000);
        step(); step(); step();
        chk("mid_rst_stale", {15'b0, valid0}, 16'h0);

        chk("lo_queue_drained", 16'(exp_q0.size()), 16'd0);
        chk("hi_queue_drained", 16'(exp_q1.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
